// File: rtl/shiftdist_pipe.sv
// ---------------------------------------------------------------------------
// shiftdist_pipe
//
// Two-stage pipelined shift-distance unit for the rounder datapath.
//
// Each operation produces the significand shift distance in one of two ways:
//   * normal path : the zero-extended leading-zero count (left shift).
//   * denorm path : er + emax(fmt). This path is taken when the result is tiny
//                   and the underflow trap is off. Right shifts longer than
//                   SATR are clamped to -SATR and flagged on sat.
//
// Stage 1 registers the operands. Stage 2 registers the result, and the
// outputs are taken straight from stage 2. Both stages use valid/ready
// handshakes and advance when the stage after them is free or being drained.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input operation present
//   in_ready   unit accepts the input this cycle
//   er[EW]     rounded-path exponent, two's complement
//   lz[LZW]    leading-zero count, unsigned
//   fmt[2]     00 single, 01 double, 10 half, 11 treated as double
//   tiny       result is tiny
//   unfen      underflow trap enabled
//   out_valid  result present
//   out_ready  downstream accepts the result
//   sh[EW]     shift distance, two's complement (negative = right shift)
//   sat        the denormalisation shift was clamped
//   denorm     the denormalisation path was selected
// ---------------------------------------------------------------------------
module shiftdist_pipe #(
    parameter int EW   = 13,
    parameter int LZW  = 6,
    parameter int SATR = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] er,
    input  logic [LZW-1:0] lz,
    input  logic [1:0]    fmt,
    input  logic          tiny,
    input  logic          unfen,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] sh,
    output logic          sat,
    output logic          denorm
);

    // -SATR as an EW-bit two's-complement constant
    localparam logic [EW-1:0] SATR_V     = EW'(SATR);
    localparam logic [EW-1:0] NEG_SATR_V = ~SATR_V + EW'(1);

    // Stage 1 registers
    logic           s1_valid_q;
    logic [EW-1:0]  s1_er_q;
    logic [LZW-1:0] s1_lz_q;
    logic [1:0]     s1_fmt_q;
    logic           s1_path_q;

    // Stage 2 registers
    logic           s2_valid_q;
    logic [EW-1:0]  sh_q;
    logic           sat_q;
    logic           denorm_q;

    // Next-state values computed from stage 1
    logic [EW-1:0]  emax;
    logic [EW-1:0]  sum;
    logic [EW-1:0]  sh_d;
    logic           sat_d;
    logic           denorm_d;

    logic           s1_en;
    logic           s2_en;

    // Handshake: a stage loads when it is empty or its content moves on.
    // in_ready is combinational from out_ready on purpose.
    assign s2_en    = ~s2_valid_q | out_ready;
    assign s1_en    = ~s1_valid_q | s2_en;
    assign in_ready = s1_en;

    always_comb begin
        emax = EW'(1023);
        case (s1_fmt_q)
            2'b00:   emax = EW'(127);
            2'b10:   emax = EW'(15);
            default: emax = EW'(1023);
        endcase
    end

    // Wraps modulo 2^EW; the carry-out is deliberately discarded
    assign sum = s1_er_q + emax;

    always_comb begin
        sh_d     = {{(EW-LZW){1'b0}}, s1_lz_q};
        sat_d    = 1'b0;
        denorm_d = 1'b0;
        if (s1_path_q) begin
            denorm_d = 1'b1;
            if ($signed(sum) < $signed(NEG_SATR_V)) begin
                sh_d  = NEG_SATR_V;
                sat_d = 1'b1;
            end else begin
                sh_d  = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_er_q    <= '0;
            s1_lz_q    <= '0;
            s1_fmt_q   <= '0;
            s1_path_q  <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_er_q   <= er;
                s1_lz_q   <= lz;
                s1_fmt_q  <= fmt;
                s1_path_q <= tiny & ~unfen;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sh_q       <= '0;
            sat_q      <= 1'b0;
            denorm_q   <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            // A bubble leaves the last result's data in place
            if (s1_valid_q) begin
                sh_q     <= sh_d;
                sat_q    <= sat_d;
                denorm_q <= denorm_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sh        = sh_q;
    assign sat       = sat_q;
    assign denorm    = denorm_q;

endmodule

// File: tb/tb_shiftdist_pipe.sv
// ---------------------------------------------------------------------------
// tb_shiftdist_pipe
//
// Directed-vector bench for shiftdist_pipe with hand-computed expectations
// (EW=13, LZW=6, SATR=64).
// ---------------------------------------------------------------------------
module tb_shiftdist_pipe;

    localparam int EW  = 13;
    localparam int LZW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] er;
    logic [LZW-1:0] lz;
    logic [1:0]    fmt;
    logic          tiny;
    logic          unfen;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] sh;
    logic          sat;
    logic          denorm;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [EW-1:0]  er;
        logic [LZW-1:0] lz;
        logic [1:0]     fmt;
        logic           tiny;
        logic           unfen;
        logic [EW-1:0]  xsh;
        logic           xsat;
        logic           xden;
    } vec_t;

    vec_t vecs [10];
    vec_t bp   [4];

    shiftdist_pipe #(.EW(EW), .LZW(LZW), .SATR(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .er        (er),
        .lz        (lz),
        .fmt       (fmt),
        .tiny      (tiny),
        .unfen     (unfen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh        (sh),
        .sat       (sat),
        .denorm    (denorm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic drive(input vec_t v);
        er    = v.er;
        lz    = v.lz;
        fmt   = v.fmt;
        tiny  = v.tiny;
        unfen = v.unfen;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, ".valid"},  32'(out_valid), 32'd1);
        chk({tag, ".sh"},     32'(sh),        32'(v.xsh));
        chk({tag, ".sat"},    32'(sat),       32'(v.xsat));
        chk({tag, ".denorm"}, 32'(denorm),    32'(v.xden));
    endtask

    // One operation through an otherwise idle pipe, checking 2-cycle latency
    task automatic send_one(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 check_out(tag, v);
    endtask

    initial begin
        //              er       lz     fmt    t  u  xsh      sat  den
        vecs[0] = '{13'h1F7E, 6'd0,  2'b00, 1'b1, 1'b0, 13'h1FFD, 1'b0, 1'b1}; // single -130
        vecs[1] = '{13'h1BB4, 6'd0,  2'b01, 1'b1, 1'b0, 13'h1FC0, 1'b1, 1'b1}; // double -1100, sat
        vecs[2] = '{13'h1F7E, 6'd5,  2'b10, 1'b1, 1'b1, 13'h0005, 1'b0, 1'b0}; // trap on -> lz
        vecs[3] = '{13'h1F7E, 6'd63, 2'b10, 1'b0, 1'b0, 13'h003F, 1'b0, 1'b0}; // not tiny, lz 63
        vecs[4] = '{13'h1FEC, 6'd0,  2'b10, 1'b1, 1'b0, 13'h1FFB, 1'b0, 1'b1}; // half -20
        vecs[5] = '{13'h1BC1, 6'd0,  2'b01, 1'b1, 1'b0, 13'h1FC0, 1'b0, 1'b1}; // sum = -64 exactly
        vecs[6] = '{13'h1BC0, 6'd0,  2'b01, 1'b1, 1'b0, 13'h1FC0, 1'b1, 1'b1}; // sum = -65
        vecs[7] = '{13'h1C18, 6'd0,  2'b11, 1'b1, 1'b0, 13'h0017, 1'b0, 1'b1}; // fmt 11 as double
        vecs[8] = '{13'h000A, 6'd0,  2'b00, 1'b1, 1'b0, 13'h0089, 1'b0, 1'b1}; // positive sum
        vecs[9] = '{13'h0FFF, 6'd0,  2'b01, 1'b1, 1'b0, 13'h1FC0, 1'b1, 1'b1}; // wraps to negative

        bp[0] = vecs[0];
        bp[1] = '{13'h0000, 6'd7, 2'b00, 1'b0, 1'b0, 13'h0007, 1'b0, 1'b0};
        bp[2] = vecs[1];
        bp[3] = vecs[4];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        er = '0; lz = '0; fmt = '0; tiny = 1'b0; unfen = 1'b0;

        // Reset state
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sh",        32'(sh),        32'd0);
        chk("rst.sat",       32'(sat),       32'd0);
        chk("rst.denorm",    32'(denorm),    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Directed single operations
        for (int i = 0; i < 10; i++) send_one($sformatf("v%0d", i), vecs[i]);

        // Backpressure: 4 cycles stalled, then drain
        begin
            int acc_idx = 0;
            int out_idx = 0;
            logic acc;
            for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
                @(negedge clk);
                out_ready = (cyc >= 4);
                in_valid  = (acc_idx < 4);
                if (acc_idx < 4) drive(bp[acc_idx]);
                #1;
                if (cyc == 3) begin
                    chk("bp.accepted", 32'(acc_idx), 32'd2);
                    chk("bp.in_ready_stall", 32'(in_ready), 32'd0);
                end
                if (out_valid) begin
                    // While stalled this rechecks the held head result
                    check_out($sformatf("bp%0d.c%0d", out_idx, cyc), bp[out_idx]);
                    if (out_ready) out_idx++;
                end
                acc = in_valid & in_ready;
                @(posedge clk);
                if (acc) acc_idx++;
            end
            chk("bp.drained", 32'(out_idx), 32'd4);
            @(negedge clk);
            in_valid = 1'b0;
        end

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("mid.full_valid", 32'(out_valid), 32'd1);
        chk("mid.full_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1 chk("mid.async_drop", 32'(out_valid), 32'd0);
        chk("mid.sh_clr", 32'(sh), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid.in_ready", 32'(in_ready), 32'd1);
        send_one("post", vecs[4]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
